// File: rtl/add_accum_pkg.sv
// Shared types and widths for the add_accum group accumulator.
package add_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int OPERAND_W = 33;
  localparam int COUNT_W   = 8;

endpackage

// File: rtl/add_accum.sv
// Accumulates {cout,sum} adder results into groups and hands each group total downstream.
// Build option: define ADD_ACCUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module add_accum
  import add_accum_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_sum,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  // Handshake: a term moves when in_valid && in_ready; a total moves when
  // out_valid && out_ready. Neither valid waits on its own ready.

  state_t               state;
  state_t               state_n;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_n;
  logic [COUNT_W-1:0]   count;
  logic [COUNT_W-1:0]   count_n;
  logic                 ovf;
  logic                 ovf_n;
  logic [ACC_W-1:0]     operand;
  logic [ACC_W:0]       sum_ext;
  logic                 carry;
  logic                 xfer;
  logic                 close;

  assign operand = {{(ACC_W-OPERAND_W){1'b0}}, in_cout, in_sum};
  assign sum_ext = {1'b0, acc} + {1'b0, operand};
  assign carry   = sum_ext[ACC_W];

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign xfer      = in_valid && in_ready;

  // The first term of a group discards whatever the accumulator held before.
  assign count_n = (state == IDLE) ? COUNT_W'(1) : count + COUNT_W'(1);
  assign close   = (count_n == COUNT_W'(N_TERMS)) || in_last;

  always_comb begin
    acc_n = sum_ext[ACC_W-1:0];
    ovf_n = ovf | carry;
    if (state == IDLE) begin
      acc_n = operand;
      ovf_n = 1'b0;
    end
`ifdef ADD_ACCUM_SAT_EN
    else if (carry) begin
      acc_n = {ACC_W{1'b1}};
    end
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, ACCUM: begin
        if (xfer) state_n = close ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) begin
        acc   <= acc_n;
        count <= count_n;
        ovf   <= ovf_n;
      end
    end
  end

  assign out_total = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: default, 34-bit and single-term instances.
module tb_add_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance
  logic        v = 0, c = 0, l = 0, ordy = 0;
  logic [31:0] s = 0;
  logic        rdy, ov, ovf;
  logic [39:0] tot;
  logic [7:0]  cnt;

  // ACC_W = 34 instance
  logic        v34 = 0, c34 = 0, l34 = 0, ordy34 = 0;
  logic [31:0] s34 = 0;
  logic        rdy34, ov34, ovf34;
  logic [33:0] tot34;
  logic [7:0]  cnt34;

  // N_TERMS = 1 instance
  logic        v1 = 0, c1 = 0, l1 = 0, ordy1 = 0;
  logic [31:0] s1 = 0;
  logic        rdy1, ov1, ovf1;
  logic [39:0] tot1;
  logic [7:0]  cnt1;

  add_accum dut (
    .clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy), .in_sum(s), .in_cout(c),
    .in_last(l), .out_valid(ov), .out_ready(ordy), .out_total(tot), .out_ovf(ovf),
    .out_count(cnt)
  );

  add_accum #(.ACC_W(34)) dut34 (
    .clk(clk), .rst(rst), .in_valid(v34), .in_ready(rdy34), .in_sum(s34), .in_cout(c34),
    .in_last(l34), .out_valid(ov34), .out_ready(ordy34), .out_total(tot34), .out_ovf(ovf34),
    .out_count(cnt34)
  );

  add_accum #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_sum(s1), .in_cout(c1),
    .in_last(l1), .out_valid(ov1), .out_ready(ordy1), .out_total(tot1), .out_ovf(ovf1),
    .out_count(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one term on the default instance for one clock edge.
  task automatic send(input logic [32:0] term, input logic last);
    v = 1'b1;
    {c, s} = term;
    l = last;
    @(negedge clk);
    v = 1'b0;
    l = 1'b0;
  endtask

  task automatic release_hold();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  localparam logic [33:0] EXP34 =
`ifdef ADD_ACCUM_SAT_EN
    34'h3FFFFFFFF;
`else
    34'h3FFFFFFFC;
`endif

  logic [31:0] vals1 [4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF};

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_total", 64'(tot), 64'd0);
    chk("rst_out_count", 64'(cnt), 64'd0);
    chk("rst_out_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(rdy), 64'd1);

    // out_ready while idle does nothing
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("idle_ordy_valid", 64'(ov), 64'd0);

    // four-term group with a carry-in term
    send({1'b0, 32'h0000000C}, 1'b0);
    send({1'b0, 32'h0000000B}, 1'b0);
    send({1'b1, 32'h00000000}, 1'b0);
    chk("g1_mid_valid", 64'(ov), 64'd0);
    chk("g1_mid_count", 64'(cnt), 64'd3);
    send({1'b0, 32'hCCCCAAAA}, 1'b0);
    chk("g1_valid", 64'(ov), 64'd1);
    chk("g1_ready", 64'(rdy), 64'd0);
    chk("g1_total", 64'(tot), 64'h01CCCCAAC1);
    chk("g1_count", 64'(cnt), 64'd4);
    chk("g1_ovf", 64'(ovf), 64'd0);
    release_hold();
    chk("g1_drop_valid", 64'(ov), 64'd0);
    chk("g1_idle_ready", 64'(rdy), 64'd1);

    // early close with in_last
    send({1'b0, 32'd5}, 1'b0);
    send({1'b0, 32'd7}, 1'b1);
    chk("g2_valid", 64'(ov), 64'd1);
    chk("g2_total", 64'(tot), 64'd12);
    chk("g2_count", 64'(cnt), 64'd2);

    // stall in HOLD with an upstream term waiting
    v = 1'b1;
    {c, s} = {1'b0, 32'd99};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", 64'(rdy), 64'd0);
      chk("stall_valid", 64'(ov), 64'd1);
      chk("stall_total", 64'(tot), 64'd12);
      chk("stall_count", 64'(cnt), 64'd2);
    end
    v = 1'b0;
    release_hold();
    chk("stall_drop_valid", 64'(ov), 64'd0);
    send({1'b0, 32'd3}, 1'b0);
    send({1'b0, 32'd4}, 1'b1);
    chk("fresh_total", 64'(tot), 64'd7);
    chk("fresh_count", 64'(cnt), 64'd2);
    release_hold();

    // reset mid-group, with a term offered in the reset cycle
    send({1'b0, 32'd100}, 1'b0);
    send({1'b0, 32'd200}, 1'b0);
    rst = 1'b1;
    v = 1'b1;
    {c, s} = {1'b0, 32'd999};
    @(negedge clk);
    rst = 1'b0;
    v = 1'b0;
    chk("midrst_count", 64'(cnt), 64'd0);
    chk("midrst_valid", 64'(ov), 64'd0);
    chk("midrst_total", 64'(tot), 64'd0);
    send({1'b0, 32'd1}, 1'b0);
    send({1'b0, 32'd2}, 1'b0);
    send({1'b0, 32'd3}, 1'b0);
    send({1'b0, 32'd4}, 1'b1);  // count limit and in_last together
    chk("postrst_total", 64'(tot), 64'd10);
    chk("postrst_count", 64'(cnt), 64'd4);
    release_hold();
    @(negedge clk);
    chk("both_close_once", 64'(ov), 64'd0);

    // 34-bit accumulator overflow
    v34 = 1'b1;
    {c34, s34} = {1'b1, 32'hFFFFFFFF};
    repeat (4) @(negedge clk);
    v34 = 1'b0;
    chk("w34_valid", 64'(ov34), 64'd1);
    chk("w34_ovf", 64'(ovf34), 64'd1);
    chk("w34_total", 64'(tot34), 64'(EXP34));
    chk("w34_count", 64'(cnt34), 64'd4);

    // single-term groups back to back
    ordy1 = 1'b1;
    v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s1 = vals1[k];
      @(negedge clk);
      chk("n1_valid", 64'(ov1), 64'd1);
      chk("n1_total", 64'(tot1), 64'(vals1[k]));
      chk("n1_count", 64'(cnt1), 64'd1);
      @(negedge clk);
      chk("n1_gap", 64'(ov1), 64'd0);
    end
    v1 = 1'b0;
    ordy1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_accum.md
ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, giving the number of adder results per group (1..255).
REQ-002 SHALL have parameter ACC_W, default 40, giving the accumulator width in bits (34..64).
REQ-003 SHALL have port clk, input, 1, the only clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an upstream adder result is present.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a result this cycle.
REQ-007 SHALL have port in_sum, input, 32, the upstream adder sum.
REQ-008 SHALL have port in_cout, input, 1, the upstream adder carry-out.
REQ-009 SHALL have port in_last, input, 1, meaning close the group after this term.
REQ-010 SHALL have port out_valid, output, 1, meaning the group total is available.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream takes the total.
REQ-012 SHALL have port out_total, output, ACC_W, the group total.
REQ-013 SHALL have port out_ovf, output, 1, a sticky flag set if any addition in the group exceeded ACC_W.
REQ-014 SHALL have port out_count, output, 8, the number of terms accepted in the group.

Function
REQ-015 The operand SHALL be {in_cout,in_sum}, 33 bits, zero-extended to ACC_W; an input transfer occurs only when in_valid && in_ready.
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 On a transfer in IDLE: acc <= operand (the stale value is discarded), count <= 1, ovf <= 0, next state ACCUM.
REQ-018 On a transfer in ACCUM: acc <= acc + operand (ACC_W+1-bit add), count <= count+1, and ovf <= ovf | carry out of bit ACC_W-1.
REQ-019 After a transfer where the new count == N_TERMS or in_last == 1, the next state SHALL be HOLD; both conditions together SHALL act once, and N_TERMS=1 SHALL go from IDLE straight to HOLD.
REQ-020 out_valid SHALL be 1 exactly in HOLD, asserted the cycle after the closing transfer (latency 1).
REQ-021 In HOLD, out_total, out_ovf and out_count SHALL stay stable until out_ready is sampled high; the block then returns to IDLE and out_valid drops the next cycle.
REQ-022 in_valid without ready, or out_ready with out_valid == 0, SHALL have no effect.
REQ-023 Without the config macro, overflow SHALL wrap modulo 2^ACC_W.

Reset
REQ-024 rst SHALL force state IDLE and set out_valid=0, out_total=0, out_ovf=0 and out_count=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-025 rst SHALL take priority over any transfer in the same cycle; a partial or held group SHALL be dropped.

Configuration
REQ-026 With ADD_ACCUM_SAT_EN defined, an overflowing addition SHALL set acc to all-ones, and acc SHALL stay there for the rest of the group, with out_ovf=1.
REQ-027 Without ADD_ACCUM_SAT_EN, the wrap behaviour of REQ-023 applies and no saturation logic SHALL exist.

Structure
REQ-028 Package add_accum_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD), the operand width constant (33) and the count width constant (8).
REQ-029 The design SHALL be a single module with no sub-module; the FSM and datapath are small enough to stay inline.

Verification
REQ-030 Default parameters, terms {0,0x0000000C}, {0,0x0000000B}, {1,0x00000000}, {0,0xCCCCAAAA} -> out_total=0x01CCCCAAC1, out_count=4, out_ovf=0.
REQ-031 Term {0,5}, then {0,7} with in_last=1 -> HOLD after 2 terms, out_total=12, out_count=2.
REQ-032 ACC_W=34, four terms {1,0xFFFFFFFF} -> out_ovf=1, out_total=0x3FFFFFFFC; with ADD_ACCUM_SAT_EN -> out_total=0x3FFFFFFFF.
REQ-033 HOLD with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> IDLE next cycle, and the next term starts a fresh group.
REQ-034 rst pulse after 2 of 4 terms -> out_count=0, out_valid=0, and the next 4 terms produce a total that excludes the pre-reset terms.
REQ-035 N_TERMS=1 with back-to-back in_valid, out_ready held 1 -> one total every 2 cycles, each equal to its operand.
